mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, giving the maximum cycles spent in RD_WAIT before abort.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state changes on posedge.
REQ-003 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port req, input, 4 bits, indexed i = 2*tid + kind (kind 0 = fetch, 1 = data); bit i = request i pending.
REQ-005 SHALL have port req_rnotw, input, 4 bits: per-requester 1 = read, 0 = write.
REQ-006 SHALL have port req_addr, input, 64 bits: four packed 16-bit addresses, requester i at [16i+15:16i].
REQ-007 SHALL have port req_wdata, input, 64 bits: four packed 16-bit write words, same packing as req_addr.
REQ-008 SHALL have port gnt, output, 4 bits: one-hot, one-cycle pulse marking acceptance.
REQ-009 SHALL have port done, output, 4 bits: one-hot, one-cycle pulse marking completion.
REQ-010 SHALL have port err, output, 4 bits: one-hot, one-cycle pulse marking a read timeout.
REQ-011 SHALL have port rdata, output, 16 bits: read result, valid while done is high for a read.
REQ-012 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-013 SHALL have port mem_strobe, output, 1 bit: memory strobe.
REQ-014 SHALL have ports mem_rnotw, output, 1 bit, and mem_addr / mem_wdata, output, 16 bits each: memory command fields.
REQ-015 SHALL have ports mem_mfc, input, 1 bit, and mem_rdata, input, 16 bits: memory completion and read data.

Function
REQ-016 SHALL implement FSM states IDLE, RD_WAIT and WR_DONE.
REQ-017 In IDLE with any req bit set, SHALL select exactly one winner.
REQ-018 Winner selection SHALL give data requests (bits 1, 3) priority over fetch requests (bits 0, 2).
REQ-019 Within a kind, SHALL prefer the thread that is not last_tid, falling back to last_tid if only it requests.
REQ-020 On the grant edge SHALL pulse gnt[winner], latch the winner's addr/wdata/rnotw into mem_addr/mem_wdata/mem_rnotw, drive mem_strobe=1, set last_tid to the winner's tid, and record the owner.
REQ-021 mem_strobe SHALL be high for exactly one cycle per transaction and SHALL be 0 in every other cycle.
REQ-022 After a read grant SHALL enter RD_WAIT and clear the timeout counter.
REQ-023 After a write grant SHALL enter WR_DONE.
REQ-024 In WR_DONE SHALL pulse done[owner] on the next edge and return to IDLE; rdata SHALL be unchanged.
REQ-025 In RD_WAIT, on the edge sampling mem_mfc=1, SHALL register rdata<=mem_rdata, pulse done[owner] and return to IDLE.
REQ-026 In RD_WAIT with mem_mfc=0 SHALL increment the counter; on the edge where the counter reaches TIMEOUT SHALL pulse err[owner] and return to IDLE, with rdata unchanged and no done.
REQ-027 mem_mfc SHALL be ignored in IDLE and WR_DONE (stray pulse: no done, no state change).
REQ-028 A request SHALL be held by its requester until its gnt; after gnt it MAY be dropped, and address changes after gnt SHALL NOT affect the transaction.
REQ-029 The next grant SHALL occur no earlier than the edge after done/err (a one-cycle IDLE sample minimum).
REQ-030 At most one transaction SHALL be outstanding; requests arriving while busy SHALL wait without loss.
REQ-031 gnt, done and err SHALL never be asserted simultaneously for the same requester.
REQ-032 The counter SHALL be wide enough for TIMEOUT and SHALL NOT wrap.

Reset
REQ-033 While reset is high SHALL force: state IDLE; gnt, done, err, busy, and mem_strobe = 0; mem_rnotw=1; mem_addr, mem_wdata, and rdata = 0; counter 0; last_tid=1, so thread 0 wins the first tie.
REQ-034 Reset asserted mid-transaction SHALL abandon it with no done/err pulse.

Verification
REQ-035 After reset, req=4'b0101 (both fetch), reads: gnt=0001 first; after its done, gnt=0100; then 0001 again while both are held.
REQ-036 req=4'b0011, addr1=0x0040, read, memory mfc with 0xBEEF: gnt=0010 first; done=0010 with rdata=0xBEEF; mem_strobe a single one-cycle pulse at addr 0x0040.
REQ-037 Write, req bit3, addr 0x1234, wdata 0x00AA: mem_strobe=1 with rnotw=0 for one cycle; done=1000 the following edge; busy low the cycle after.
REQ-038 Read with mem_mfc held 0: err[owner] pulses exactly TIMEOUT(15) cycles after entering RD_WAIT, then IDLE; a later read completes normally.
REQ-039 Reset pulsed during RD_WAIT, followed by an mfc pulse: all outputs 0 and mem_rnotw=1, no done; after reset, the stray mfc is ignored.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates four requesters (two threads x {fetch, data}) onto a single
//   memory command port. Only one transaction is outstanding at a time.
//   Data requests beat fetch requests. Within a kind, the thread that did not
//   win last time is preferred. Reads wait for mem_mfc or abort after TIMEOUT
//   cycles. Writes complete one cycle after the strobe.
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   req[3:0]          : pending requests, index = 2*tid + kind (kind 1 = data)
//   req_rnotw[3:0]    : per-requester direction, 1 = read
//   req_addr[63:0]    : four packed 16-bit addresses (requester i at [16i+:16])
//   req_wdata[63:0]   : four packed 16-bit write words, same packing
//   gnt/done/err[3:0] : one-hot single-cycle pulses (accept / complete / timeout)
//   rdata[15:0]       : read result, valid while done is high for a read
//   busy              : high whenever a transaction is in flight
//   mem_strobe        : one-cycle command strobe
//   mem_rnotw, mem_addr, mem_wdata : command fields, held for the transaction
//   mem_mfc, mem_rdata: memory completion and read data
module mem_port_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [3:0]  req_rnotw,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic [3:0]  err,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        mem_strobe,
    output logic        mem_rnotw,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_mfc,
    input  logic [15:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_DONE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last_tid;
    logic [1:0]    owner;

    // Winner selection: pick the kind first, then the thread within it.
    logic       data_any;
    logic [1:0] pair;
    logic       win_tid;
    logic [1:0] win_idx;

    always_comb begin
        data_any = req[1] | req[3];
        pair     = data_any ? {req[3], req[1]} : {req[2], req[0]};
        // Both threads asking: alternate away from the last winner.
        win_tid  = (pair == 2'b11) ? ~last_tid : pair[1];
        win_idx  = {win_tid, data_any};
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_tid   <= 1'b1;
            owner      <= 2'd0;
            gnt        <= 4'b0;
            done       <= 4'b0;
            err        <= 4'b0;
            rdata      <= 16'h0;
            mem_strobe <= 1'b0;
            mem_rnotw  <= 1'b1;
            mem_addr   <= 16'h0;
            mem_wdata  <= 16'h0;
        end else begin
            // Pulses default low every cycle.
            gnt        <= 4'b0;
            done       <= 4'b0;
            err        <= 4'b0;
            mem_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt        <= 4'b0001 << win_idx;
                        mem_strobe <= 1'b1;
                        mem_addr   <= req_addr[{win_idx, 4'b0000} +: 16];
                        mem_wdata  <= req_wdata[{win_idx, 4'b0000} +: 16];
                        mem_rnotw  <= req_rnotw[win_idx];
                        last_tid   <= win_tid;
                        owner      <= win_idx;
                        cnt        <= '0;
                        state      <= req_rnotw[win_idx] ? RD_WAIT : WR_DONE;
                    end
                end
                WR_DONE: begin
                    done  <= 4'b0001 << owner;
                    state <= IDLE;
                end
                RD_WAIT: begin
                    if (mem_mfc) begin
                        rdata <= mem_rdata;
                        done  <= 4'b0001 << owner;
                        state <= IDLE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        // Counter reaches TIMEOUT on this edge: abort.
                        cnt   <= CW'(TIMEOUT);
                        err   <= 4'b0001 << owner;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  req_rnotw;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [3:0]  gnt, done, err;
    logic [15:0] rdata;
    logic        busy, mem_strobe, mem_rnotw;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_mfc;
    logic [15:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .req(req), .req_rnotw(req_rnotw),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .err(err), .rdata(rdata), .busy(busy), .mem_strobe(mem_strobe),
        .mem_rnotw(mem_rnotw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_mfc(mem_mfc), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; req = 4'b0; req_rnotw = 4'b1111;
        req_addr = {16'h0400, 16'h0200, 16'h0300, 16'h0100};
        req_wdata = 64'h0; mem_mfc = 1'b0; mem_rdata = 16'h0;
        step(); step();

        // Reset state
        chk("rst_gnt", gnt, 4'b0);
        chk("rst_done", done, 4'b0);
        chk("rst_err", err, 4'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobe", mem_strobe, 1'b0);
        chk("rst_rnotw", mem_rnotw, 1'b1);
        chk("rst_addr", mem_addr, 16'h0);
        chk("rst_rdata", rdata, 16'h0);
        reset = 1'b0;

        // Both fetch requests held: 0001, 0100, 0001
        req = 4'b0101;
        step();
        chk("a_gnt0", gnt, 4'b0001);
        chk("a_strobe0", mem_strobe, 1'b1);
        chk("a_addr0", mem_addr, 16'h0100);
        chk("a_rnotw0", mem_rnotw, 1'b1);
        chk("a_busy0", busy, 1'b1);
        step();
        chk("a_strobe_off", mem_strobe, 1'b0);
        chk("a_gnt_off", gnt, 4'b0);
        mem_mfc = 1'b1; mem_rdata = 16'h1111;
        step();
        mem_mfc = 1'b0;
        chk("a_done0", done, 4'b0001);
        chk("a_rdata0", rdata, 16'h1111);
        chk("a_busy_idle", busy, 1'b0);
        step();
        chk("a_gnt1", gnt, 4'b0100);
        chk("a_addr1", mem_addr, 16'h0200);
        mem_mfc = 1'b1; mem_rdata = 16'h2222;
        step();
        mem_mfc = 1'b0;
        chk("a_done1", done, 4'b0100);
        step();
        chk("a_gnt2", gnt, 4'b0001);
        req = 4'b0;
        mem_mfc = 1'b1; mem_rdata = 16'h3333;
        step();
        mem_mfc = 1'b0;
        chk("a_done2", done, 4'b0001);

        // Data beats fetch; read completes with BEEF; addr change after gnt ignored
        req = 4'b0011; req_addr[31:16] = 16'h0040;
        step();
        chk("b_gnt", gnt, 4'b0010);
        chk("b_strobe", mem_strobe, 1'b1);
        chk("b_addr", mem_addr, 16'h0040);
        req = 4'b0; req_addr[31:16] = 16'hFFFF;
        step();
        chk("b_strobe_off", mem_strobe, 1'b0);
        chk("b_addr_held", mem_addr, 16'h0040);
        mem_mfc = 1'b1; mem_rdata = 16'hBEEF;
        step();
        mem_mfc = 1'b0;
        chk("b_done", done, 4'b0010);
        chk("b_rdata", rdata, 16'hBEEF);
        chk("b_strobe_end", mem_strobe, 1'b0);

        // Write from requester 3; stray mfc in WR_DONE ignored
        req = 4'b1000; req_rnotw = 4'b0111;
        req_addr[63:48] = 16'h1234; req_wdata[63:48] = 16'h00AA;
        step();
        chk("c_gnt", gnt, 4'b1000);
        chk("c_strobe", mem_strobe, 1'b1);
        chk("c_rnotw", mem_rnotw, 1'b0);
        chk("c_addr", mem_addr, 16'h1234);
        chk("c_wdata", mem_wdata, 16'h00AA);
        req = 4'b0; req_rnotw = 4'b1111;
        mem_mfc = 1'b1; mem_rdata = 16'hDEAD;
        step();
        chk("c_done", done, 4'b1000);
        chk("c_strobe_off", mem_strobe, 1'b0);
        chk("c_rdata_kept", rdata, 16'hBEEF);
        // mfc still high: stray pulse in IDLE
        step();
        mem_mfc = 1'b0;
        chk("c_busy_after", busy, 1'b0);
        chk("c_stray_done", done, 4'b0);
        chk("c_stray_rdata", rdata, 16'hBEEF);

        // Read timeout after 15 cycles in RD_WAIT
        req = 4'b0001; req_addr[15:0] = 16'h0500;
        step();
        chk("d_gnt", gnt, 4'b0001);
        req = 4'b0;
        for (int k = 1; k < 15; k++) begin
            step();
            chk("d_no_err", err, 4'b0);
        end
        step();
        chk("d_err", err, 4'b0001);
        chk("d_no_done", done, 4'b0);
        chk("d_rdata_kept", rdata, 16'hBEEF);
        chk("d_busy", busy, 1'b0);
        step();
        chk("d_err_pulse", err, 4'b0);
        req = 4'b0100;
        step();
        chk("d_gnt2", gnt, 4'b0100);
        req = 4'b0;
        mem_mfc = 1'b1; mem_rdata = 16'h5555;
        step();
        mem_mfc = 1'b0;
        chk("d_done2", done, 4'b0100);
        chk("d_rdata2", rdata, 16'h5555);

        // Reset during RD_WAIT, then stray mfc
        req = 4'b0001;
        step();
        chk("e_gnt", gnt, 4'b0001);
        req = 4'b0;
        step();
        reset = 1'b1;
        #1;
        chk("e_rst_busy", busy, 1'b0);
        chk("e_rst_rnotw", mem_rnotw, 1'b1);
        chk("e_rst_addr", mem_addr, 16'h0);
        chk("e_rst_rdata", rdata, 16'h0);
        mem_mfc = 1'b1; mem_rdata = 16'h9999;
        step();
        chk("e_rst_done", done, 4'b0);
        reset = 1'b0;
        step();
        mem_mfc = 1'b0;
        chk("e_stray_done", done, 4'b0);
        chk("e_stray_busy", busy, 1'b0);
        chk("e_stray_rdata", rdata, 16'h0);
        // last_tid back to 1: thread 0 wins the tie
        req = 4'b0101;
        step();
        chk("e_gnt_tie", gnt, 4'b0001);
        req = 4'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
